// File: rtl/token_step_sequencer.sv
// rtl/token_step_sequencer.sv - steps a player token square by square via coordinate LUT and box plotter
module token_step_sequencer #(
    parameter int STEP_DELAY = 12500000,
    parameter int DELAY_W    = 24,
    parameter int LAST_SQ    = 100
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] steps,
    output logic [6:0] lut_number,
    input  logic [8:0] lut_x,
    input  logic [8:0] lut_y,
    output logic [8:0] plot_x,
    output logic [8:0] plot_y,
    output logic       plot_erase,
    output logic       draw_req,
    input  logic       draw_ack,
    output logic [6:0] position,
    output logic       busy,
    output logic       done,
    output logic       no_move,
    output logic       win
);

    localparam logic [3:0] S_INIT_LK0  = 4'd0;
    localparam logic [3:0] S_INIT_LK1  = 4'd1;
    localparam logic [3:0] S_INIT_DRAW = 4'd2;
    localparam logic [3:0] S_IDLE      = 4'd3;
    localparam logic [3:0] S_ERASE     = 4'd4;
    localparam logic [3:0] S_LK0       = 4'd5;
    localparam logic [3:0] S_LK1       = 4'd6;
    localparam logic [3:0] S_DRAW      = 4'd7;
    localparam logic [3:0] S_DWELL     = 4'd8;
    localparam logic [3:0] S_FINISH    = 4'd9;

    logic [3:0]         state_q, state_d;
    logic [6:0]         pos_q, pos_d;
    logic [6:0]         lutn_q, lutn_d;
    logic [6:0]         target_q, target_d;
    logic [8:0]         cur_x_q, cur_x_d;
    logic [8:0]         cur_y_q, cur_y_d;
    logic [8:0]         plot_x_q, plot_x_d;
    logic [8:0]         plot_y_q, plot_y_d;
    logic               erase_q, erase_d;
    logic               req_q, req_d;
    logic               nm_q, nm_d;
    logic               win_q, win_d;
    logic [DELAY_W-1:0] dwell_q, dwell_d;

    logic [7:0] sum;
    logic       legal;

    // 8-bit sum so an overshoot past LAST_SQ can never wrap into a legal square
    assign sum   = {1'b0, pos_q} + {5'b00000, steps};
    assign legal = (steps != 3'd0) && (steps != 3'd7) && (sum <= 8'(LAST_SQ));

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        lutn_d   = lutn_q;
        target_d = target_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        plot_x_d = plot_x_q;
        plot_y_d = plot_y_q;
        erase_d  = erase_q;
        req_d    = req_q;
        nm_d     = nm_q;
        win_d    = win_q;
        dwell_d  = dwell_q;
        case (state_q)
            S_INIT_LK0: state_d = S_INIT_LK1;
            S_INIT_LK1: begin
                cur_x_d  = lut_x;
                cur_y_d  = lut_y;
                plot_x_d = lut_x;
                plot_y_d = lut_y;
                erase_d  = 1'b0;
                req_d    = 1'b1;
                state_d  = S_INIT_DRAW;
            end
            S_INIT_DRAW: begin
                if (draw_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (start) begin
                    if (legal) begin
                        target_d = sum[6:0];
                        plot_x_d = cur_x_q;
                        plot_y_d = cur_y_q;
                        erase_d  = 1'b1;
                        req_d    = 1'b1;
                        state_d  = S_ERASE;
                    end else begin
                        nm_d    = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end
            S_ERASE: begin
                if (draw_ack) begin
                    req_d   = 1'b0;
                    lutn_d  = pos_q + 7'd1;
                    state_d = S_LK0;
                end
            end
            // two edges between lut_number change and capture let the negedge LUT settle
            S_LK0: state_d = S_LK1;
            S_LK1: begin
                cur_x_d  = lut_x;
                cur_y_d  = lut_y;
                plot_x_d = lut_x;
                plot_y_d = lut_y;
                erase_d  = 1'b0;
                req_d    = 1'b1;
                pos_d    = lutn_q;
                state_d  = S_DRAW;
            end
            S_DRAW: begin
                if (draw_ack) begin
                    req_d   = 1'b0;
                    dwell_d = DELAY_W'(STEP_DELAY - 1);
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (dwell_q == '0) begin
                    if (pos_q == target_q) begin
                        state_d = S_FINISH;
                    end else begin
                        plot_x_d = cur_x_q;
                        plot_y_d = cur_y_q;
                        erase_d  = 1'b1;
                        req_d    = 1'b1;
                        state_d  = S_ERASE;
                    end
                end else begin
                    dwell_d = dwell_q - DELAY_W'(1);
                end
            end
            S_FINISH: begin
                nm_d = 1'b0;
                if (pos_q == 7'(LAST_SQ)) begin
                    win_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_INIT_LK0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_INIT_LK0;
            pos_q    <= '0;
            lutn_q   <= '0;
            target_q <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            plot_x_q <= '0;
            plot_y_q <= '0;
            erase_q  <= 1'b0;
            req_q    <= 1'b0;
            nm_q     <= 1'b0;
            win_q    <= 1'b0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            lutn_q   <= lutn_d;
            target_q <= target_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            plot_x_q <= plot_x_d;
            plot_y_q <= plot_y_d;
            erase_q  <= erase_d;
            req_q    <= req_d;
            nm_q     <= nm_d;
            win_q    <= win_d;
            dwell_q  <= dwell_d;
        end
    end

    assign lut_number = lutn_q;
    assign plot_x     = plot_x_q;
    assign plot_y     = plot_y_q;
    assign plot_erase = erase_q;
    assign draw_req   = req_q;
    assign position   = pos_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FINISH);
    assign no_move    = nm_q;
    assign win        = win_q;

endmodule

// File: tb/tb_token_step_sequencer.sv
// tb/tb_token_step_sequencer.sv - self-checking bench for token_step_sequencer
module tb_token_step_sequencer;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [2:0] steps;
    logic [6:0] lut_number;
    logic [8:0] lut_x, lut_y;
    logic [8:0] plot_x, plot_y;
    logic       plot_erase, draw_req, draw_ack;
    logic [6:0] position;
    logic       busy, done, no_move, win;

    token_step_sequencer #(.STEP_DELAY(4), .DELAY_W(8), .LAST_SQ(100)) dut (
        .clock(clock), .resetn(resetn), .start(start), .steps(steps),
        .lut_number(lut_number), .lut_x(lut_x), .lut_y(lut_y),
        .plot_x(plot_x), .plot_y(plot_y), .plot_erase(plot_erase),
        .draw_req(draw_req), .draw_ack(draw_ack), .position(position),
        .busy(busy), .done(done), .no_move(no_move), .win(win)
    );

    int checks = 0;
    int errors = 0;
    int model_pos = 0;
    bit model_win = 0;
    int stab_err = 0;
    logic [18:0] got[$];
    logic [18:0] latched;
    int pcnt;

    typedef struct {
        logic [2:0] steps;
        logic       exp_nm;
        int         exp_pos;
    } vec_t;
    vec_t tbl[5];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // snake board: row r counts left-to-right when even, right-to-left when odd
    function automatic logic [17:0] sq_xy(int n);
        int r, c;
        if (n == 0) return {9'd5, 9'd210};
        r = (n - 1) / 10;
        c = (n - 1) % 10;
        if (r % 2 == 1) c = 9 - c;
        return {9'(14 + 30 * c), 9'(210 - 22 * r)};
    endfunction

    always @(negedge clock) {lut_x, lut_y} <= sq_xy(int'(lut_number));

    initial begin
        draw_ack = 1'b0;
        pcnt = 0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                draw_ack = 1'b0;
                pcnt = 0;
            end else if (draw_ack) begin
                draw_ack = 1'b0;
                pcnt = 0;
            end else if (draw_req) begin
                if (pcnt == 0) latched = {plot_erase, plot_x, plot_y};
                else if (latched != {plot_erase, plot_x, plot_y}) stab_err++;
                pcnt++;
                if (pcnt == 3) begin
                    draw_ack = 1'b1;
                    got.push_back(latched);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic reset_release();
        int cyc;
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("rst_draw_req", int'(draw_req), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_position", int'(position), 0);
        chk("rst_done_nm_win", int'({done, no_move, win}), 0);
        chk("rst_plot_lut", int'({plot_x, plot_y, plot_erase, lut_number}), 0);
        repeat (3) @(negedge clock);
        got.delete();
        model_pos = 0;
        model_win = 0;
        resetn = 1'b1;
        cyc = 0;
        while (busy && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        chk("init_timeout", int'(busy), 0);
        chk("init_draw_count", got.size(), 1);
        if (got.size() >= 1) chk("init_draw_xy", int'(got[0]), int'({1'b0, 9'd5, 9'd210}));
        chk("init_position", int'(position), 0);
    endtask

    task automatic do_move(input logic [2:0] s, input bit poke);
        logic [18:0] exp_q[$];
        bit legal;
        int cyc, fd, req_cycles, new_pos;
        legal = (s >= 1) && (s <= 6) && (model_pos + int'(s) <= 100);
        new_pos = legal ? model_pos + int'(s) : model_pos;
        if (legal)
            for (int k = 1; k <= int'(s); k++) begin
                exp_q.push_back({1'b1, sq_xy(model_pos + k - 1)});
                exp_q.push_back({1'b0, sq_xy(model_pos + k)});
            end
        got.delete();
        steps = s;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        fd = -1;
        req_cycles = int'(draw_req);
        while (!done && cyc < 4000) begin
            @(negedge clock);
            cyc++;
            start = 1'b0;
            if (draw_req) req_cycles++;
            if (poke && fd < 0 && got.size() >= 2) fd = cyc;
            if (poke && fd >= 0 && cyc == fd + 2) begin
                steps = 3'd5;
                start = 1'b1;
            end
        end
        chk("done_seen", int'(done), 1);
        chk("no_move", int'(no_move), legal ? 0 : 1);
        chk("position", int'(position), new_pos);
        if (!legal) begin
            chk("reject_latency_ok", int'(cyc <= 2), 1);
            chk("reject_no_req", req_cycles, 0);
        end
        model_pos = new_pos;
        if (model_pos == 100) model_win = 1;
        @(negedge clock);
        chk("done_one_cycle", int'({done, no_move}), 0);
        chk("win", int'(win), int'(model_win));
        chk("draw_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            if (got[i] != exp_q[i]) chk("draw_entry", int'(got[i]), int'(exp_q[i]));
    endtask

    task automatic walk_to(input int t);
        while (model_pos < t) do_move(3'((t - model_pos > 6) ? 6 : t - model_pos), 1'b0);
    endtask

    initial begin
        int cyc;
        tbl[0] = '{3'd3, 1'b0, 3};
        tbl[1] = '{3'd0, 1'b1, 3};
        tbl[2] = '{3'd7, 1'b1, 3};
        tbl[3] = '{3'd6, 1'b0, 9};
        tbl[4] = '{3'd3, 1'b0, 12};
        resetn = 1'b0;
        start = 1'b0;
        steps = 3'd0;
        reset_release();

        for (int i = 0; i < 5; i++) begin
            do_move(tbl[i].steps, 1'b0);
            chk("tbl_position", int'(position), tbl[i].exp_pos);
            chk("tbl_no_move_model", int'(tbl[i].exp_nm), int'(tbl[i].exp_pos == 3 && i > 0));
        end

        // reset while a draw request is outstanding mid-move at square 12
        got.delete();
        @(negedge clock);
        steps = 3'd2;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (!(got.size() >= 1 && draw_req && !plot_erase) && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        chk("midmove_req_seen", int'(draw_req), 1);
        reset_release();

        do_move(3'd2, 1'b1);
        for (int i = 0; i < 12; i++) do_move(3'($urandom_range(0, 7)), 1'b0);

        walk_to(98);
        do_move(3'd5, 1'b0);

        reset_release();
        walk_to(97);
        do_move(3'd3, 1'b0);
        chk("final_draw_xy", got.size() > 0 ? int'(got[got.size() - 1]) : -1,
            int'({1'b0, 9'd14, 9'd12}));
        do_move(3'd1, 1'b0);
        chk("plot_stable_during_req", stab_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
